// File: rtl/rgb_2_dvp_pkg.sv
// Shared types and helpers for the RGB888-to-DVP transmitter: FSM states,
// the RGB565 packing function and the colour-bar palette.
package rgb_2_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } dvp_state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Pack {R,G,B} 8:8:8 into RGB565; [15:8] is the first DVP byte, [7:0] the second.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    // Colour of vertical bar idx, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_tx_fifo.sv
// Small synchronous FIFO holding {sof, rgb888} entries ahead of the DVP serialiser.
// Pointers carry one extra wrap bit to tell full from empty.
module dvp_tx_fifo #(
    parameter int WIDTH = 25,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_o  = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted push and pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array, written on accepted push only.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/rgb_2_dvp.sv
// RGB888 valid/ready stream to OV5640-style DVP transmitter (camera emulator).
// Optional build macro TEST_PATTERN_EN adds pattern_i and an 8-bar colour pattern.
module rgb_2_dvp
    import rgb_2_dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int VS_W     = 2,
    parameter int V_BACK   = 8,
    parameter int V_FRONT  = 8,
    parameter int VS_POL   = 1,
    parameter int FIFO_AW  = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic        pix_sof_i,
    input  logic [23:0] rgb_i,
`ifdef TEST_PATTERN_EN
    input  logic        pattern_i,
`endif
    output logic        cmos_pclk_o,
    output logic        cmos_vsync_o,
    output logic        cmos_href_o,
    output logic [7:0]  cmos_data_o,
    output logic        underflow_o
);

    localparam int   LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int   HREF_END    = 2 * H_ACTIVE;
    localparam int   FRAME_LINES = VS_W + V_BACK + V_ACTIVE + V_FRONT;
    localparam int   HW          = $clog2(LINE_LEN);
    localparam int   VW          = $clog2(FRAME_LINES + 1);
    localparam logic VS_ON       = 1'(VS_POL);

    dvp_state_t  state, state_next;
    logic [HW-1:0] h_cnt, h_next;
    logic [VW-1:0] v_cnt, v_next;
    logic [VW-1:0] lines_m1;
    logic          line_end;

    logic [24:0] fifo_head;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic        vsync_d, href_d, uf_set, uf_clr;
    logic [7:0]  data_d, lo_d, pix_lo;
    logic [15:0] pix_word;
    logic        pat_active;
    logic [15:0] pat_word;

    assign pix_ready_o = ~fifo_full;
    assign fifo_push   = pix_valid_i & pix_ready_o;
    assign cmos_pclk_o = ~clk_i;

    dvp_tx_fifo #(.WIDTH(25), .AW(FIFO_AW)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .data_i  ({pix_sof_i, rgb_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic          pattern_q;
    logic [HW-1:0] pix_idx;

    // Latch the pattern select as each frame enters vsync.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pattern_q <= 1'b0;
        end else if (state != ST_VSYNC && state_next == ST_VSYNC) begin
            pattern_q <= pattern_i;
        end
    end

    assign pix_idx    = h_cnt >> 1;
    assign pat_active = pattern_q;
    assign pat_word   = bar_colour(3'(pix_idx / HW'(BAR_W)));
`else
    assign pat_active = 1'b0;
    assign pat_word   = '0;
`endif

    // Next-state and line/column counter sequencing through the frame.
    always_comb begin
        state_next = state;
        h_next     = h_cnt;
        v_next     = v_cnt;
        case (state)
            ST_VSYNC:  lines_m1 = VW'(VS_W - 1);
            ST_VBACK:  lines_m1 = VW'(V_BACK - 1);
            ST_ACTIVE: lines_m1 = VW'(V_ACTIVE - 1);
            ST_VFRONT: lines_m1 = VW'(V_FRONT - 1);
            default:   lines_m1 = '0;
        endcase
        line_end = (h_cnt == HW'(LINE_LEN - 1));
        if (state == ST_IDLE) begin
            h_next = '0;
            v_next = '0;
            if (en_i) begin
                state_next = ST_VSYNC;
            end
        end else begin
            h_next = line_end ? '0 : h_cnt + 1'b1;
            if (line_end) begin
                if (v_cnt == lines_m1) begin
                    v_next = '0;
                    case (state)
                        ST_VSYNC:  state_next = ST_VBACK;
                        ST_VBACK:  state_next = ST_ACTIVE;
                        ST_ACTIVE: state_next = ST_VFRONT;
                        ST_VFRONT: state_next = en_i ? ST_VSYNC : ST_IDLE;
                        default:   state_next = ST_IDLE;
                    endcase
                end else begin
                    v_next = v_cnt + 1'b1;
                end
            end
        end
    end

    // Output decode: sync levels, byte selection, FIFO pops and underflow events.
    always_comb begin
        fifo_pop = 1'b0;
        uf_set   = 1'b0;
        uf_clr   = 1'b0;
        vsync_d  = ~VS_ON;
        href_d   = 1'b0;
        data_d   = 8'h00;
        lo_d     = pix_lo;
        pix_word = rgb888_to_565(fifo_head[23:0]);
        case (state)
            ST_VSYNC, ST_VBACK: begin
                if (state == ST_VSYNC) begin
                    vsync_d = VS_ON;
                    if (h_cnt == '0 && v_cnt == '0) begin
                        uf_clr = 1'b1;
                    end
                end
                if (!pat_active && !fifo_empty && !fifo_head[24]) begin
                    fifo_pop = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (h_cnt < HW'(HREF_END)) begin
                    href_d = 1'b1;
                    if (!h_cnt[0]) begin
                        if (pat_active) begin
                            data_d = pat_word[15:8];
                        end else if (fifo_empty) begin
                            lo_d   = 8'h00;
                            uf_set = 1'b1;
                        end else begin
                            fifo_pop = 1'b1;
                            data_d   = pix_word[15:8];
                            lo_d     = pix_word[7:0];
                        end
                    end else begin
                        data_d = pat_active ? pat_word[7:0] : pix_lo;
                    end
                end
            end
            default: ;
        endcase
    end

    // FSM state register and frame counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Registered DVP outputs, held second byte and sticky underflow (set wins over clear).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmos_vsync_o <= ~VS_ON;
            cmos_href_o  <= 1'b0;
            cmos_data_o  <= 8'h00;
            pix_lo       <= 8'h00;
            underflow_o  <= 1'b0;
        end else begin
            cmos_vsync_o <= vsync_d;
            cmos_href_o  <= href_d;
            cmos_data_o  <= data_d;
            pix_lo       <= lo_d;
            if (uf_set) begin
                underflow_o <= 1'b1;
            end else if (uf_clr) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_2_dvp.sv
// Self-checking bench for rgb_2_dvp on a tiny frame (L=14 clocks, 70 clocks/frame).
// Expected DVP bytes are queued as pixels are driven and popped while href is high.
module tb_rgb_2_dvp;

    localparam int H_ACTIVE = 4;
    localparam int H_BLANK  = 6;
    localparam int V_ACTIVE = 2;
    localparam int VS_W     = 1;
    localparam int V_BACK   = 1;
    localparam int V_FRONT  = 1;
    localparam int VS_POL   = 1;
    localparam int FIFO_AW  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [23:0] rgb = '0;
    logic        pix_ready, pclk, vsync, href, underflow;
    logic [7:0]  data;
`ifdef TEST_PATTERN_EN
    logic        pattern = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    bit  sb_en = 1'b1;
    int  vs_cnt = 0, href_cnt = 0, href_rise = 0, blank_bad = 0;
    logic prev_href = 1'b0;

    rgb_2_dvp #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .VS_W(VS_W),
        .V_BACK(V_BACK), .V_FRONT(V_FRONT), .VS_POL(VS_POL), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .pix_sof_i    (pix_sof),
        .rgb_i        (rgb),
`ifdef TEST_PATTERN_EN
        .pattern_i    (pattern),
`endif
        .cmos_pclk_o  (pclk),
        .cmos_vsync_o (vsync),
        .cmos_href_o  (href),
        .cmos_data_o  (data),
        .underflow_o  (underflow)
    );

    always #5 clk = ~clk;

    // Reference RGB565 packing written arithmetically.
    function automatic logic [15:0] to565(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]);
        g = int'(c[15:8]);
        b = int'(c[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    // Monitor: counts sync activity and scores every href byte against the queue.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_href = 1'b0;
        end else begin
            if (vsync === 1'b1) vs_cnt++;
            if (href === 1'b1) begin
                href_cnt++;
                if (prev_href !== 1'b1) href_rise++;
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_byte: got %02h, none expected at %0t", data, $time);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (data !== e) begin
                            errors++;
                            $display("[TB] FAIL sb_byte: got %02h want %02h at %0t", data, e, $time);
                        end
                    end
                end
            end else if (data !== 8'h00) begin
                blank_bad++;
            end
            prev_href = href;
        end
    end

    task automatic reset_counters();
        vs_cnt = 0; href_cnt = 0; href_rise = 0; blank_bad = 0;
    endtask

    task automatic push_pixel(input logic sof, input logic [23:0] c, input bit expect_out);
        int waited = 0;
        logic [15:0] w;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_sof   = sof;
        rgb       = c;
        while (pix_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: ready=%0b want 1", pix_ready);
        end else if (expect_out) begin
            w = to565(c);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        @(posedge clk);
        #1 pix_valid = 1'b0;
    endtask

    task automatic run_frame();
        @(negedge clk);
        en = 1'b1;
        repeat (35) @(negedge clk);
        en = 1'b0;
        repeat (45) @(negedge clk);
    endtask

    task automatic check_frame_end(input string name, input logic want_uf);
        checks++;
        if (vs_cnt != 14) begin errors++; $display("[TB] FAIL %s_vsync_len: got %0d want 14", name, vs_cnt); end
        checks++;
        if (href_cnt != 16 || href_rise != 2) begin
            errors++; $display("[TB] FAIL %s_href: got %0d clocks/%0d pulses want 16/2", name, href_cnt, href_rise);
        end
        checks++;
        if (blank_bad != 0) begin errors++; $display("[TB] FAIL %s_blank_data: got %0d nonzero want 0", name, blank_bad); end
        checks++;
        if (underflow !== want_uf) begin errors++; $display("[TB] FAIL %s_underflow: got %0b want %0b", name, underflow, want_uf); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL %s_leftover: got %0d bytes want 0", name, exp_q.size()); end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (vsync !== 1'b0 || href !== 1'b0 || data !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_outputs: got vs=%0b href=%0b data=%02h want 0/0/00", vsync, href, data);
        end
        checks++;
        if (underflow !== 1'b0 || pix_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_flags: got uf=%0b ready=%0b want 0/1", underflow, pix_ready);
        end
        @(negedge clk);
        checks++;
        if (pclk !== 1'b1) begin errors++; $display("[TB] FAIL pclk: got %0b want 1 at clk low", pclk); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push_pixel(1'b1, 24'hABCDEF, 1'b0);
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL fifo_full: got ready=%0b want 0", pix_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL fifo_reset: got ready=%0b want 1", pix_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_pixels();
        reset_counters();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
        run_frame();
        check_frame_end("no_pixels", 1'b1);
    endtask

    task automatic test_red();
        reset_counters();
        for (int i = 0; i < 4; i++) push_pixel(i == 0, 24'hFF0000, 1'b1);
        fork
            run_frame();
            for (int i = 0; i < 4; i++) push_pixel(1'b0, 24'hFF0000, 1'b1);
        join
        check_frame_end("red", 1'b0);
    endtask

    task automatic test_pixel_values();
        reset_counters();
        push_pixel(1'b1, 24'h123456, 1'b1);
        for (int i = 0; i < 3; i++) push_pixel(1'b0, 24'($urandom), 1'b1);
        fork
            run_frame();
            for (int i = 0; i < 4; i++) push_pixel(i == 0, 24'($urandom), 1'b1);
        join
        check_frame_end("values", 1'b0);
    endtask

    task automatic test_stale();
        reset_counters();
        push_pixel(1'b0, 24'h00FF00, 1'b0);
        push_pixel(1'b0, 24'h0000FF, 1'b0);
        push_pixel(1'b0, 24'hFFFFFF, 1'b0);
        push_pixel(1'b1, 24'h808080, 1'b1);
        fork
            run_frame();
            for (int i = 0; i < 7; i++) push_pixel(1'b0, 24'h102030 + 24'(i * 24'h111111), 1'b1);
        join
        check_frame_end("stale", 1'b0);
    endtask

    task automatic test_en_drop();
        reset_counters();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
        run_frame();
        repeat (30) @(negedge clk);
        check_frame_end("en_drop", 1'b1);
        checks++;
        if (vsync !== 1'b0 || href !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_outputs: got vs=%0b href=%0b want 0/0", vsync, href);
        end
    endtask

    task automatic test_reset_mid_line();
        int waited = 0;
        sb_en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        while (href !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        en = 1'b0;
        checks++;
        if (waited >= 100) begin
            errors++; $display("[TB] FAIL mid_line_href: got href=%0b want 1 within 100 clocks", href);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (href !== 1'b0 || data !== 8'h00 || vsync !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: got href=%0b data=%02h vs=%0b uf=%0b want 0/00/0/0",
                               href, data, vsync, underflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
    endtask

    initial begin
        $display("[TB] rgb_2_dvp bench start");
        test_reset();
        test_no_pixels();
        test_red();
        test_pixel_values();
        test_stale();
        test_en_drop();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
